// File: rtl/gate_tt_checker.sv
// ============================================================================
// Module   : gate_tt_checker
// Purpose  : Walks a 2-input gate through its truth table and flags mismatches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic       err_sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] C_SEL_RSVD = 3'd7;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_a, w_a_nxt;
  logic       r_b, w_b_nxt;
  logic [3:0] r_fail, w_fail_nxt;
  logic       r_pass, w_pass_nxt;
  logic       r_err, w_err_nxt;
  logic [2:0] r_gsel, w_gsel_nxt;
  logic       w_exp;
  logic       w_hit;

  always_comb begin
    w_exp = 1'b0;
    case (r_gsel)
      3'd0:    w_exp = r_a & r_b;
      3'd1:    w_exp = r_a | r_b;
      3'd2:    w_exp = ~(r_a & r_b);
      3'd3:    w_exp = ~(r_a | r_b);
      3'd4:    w_exp = r_a ^ r_b;
      3'd5:    w_exp = ~(r_a ^ r_b);
      3'd6:    w_exp = ~r_a;
      default: w_exp = 1'b0;
    endcase
  end

  // An X/Z on dut_y makes this compare non-1, which is counted as a mismatch.
  assign w_hit = (dut_y == w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= 2'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_gsel  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_fail  <= w_fail_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_gsel  <= w_gsel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_fail_nxt  = r_fail;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_gsel_nxt  = r_gsel;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_gsel_nxt = gate_sel;
          w_pass_nxt = 1'b0;
          w_idx_nxt  = 2'd0;
          w_cnt_nxt  = 4'd0;
          w_a_nxt    = 1'b0;
          w_b_nxt    = 1'b0;
          if (gate_sel == C_SEL_RSVD) begin
            w_err_nxt   = 1'b1;
            w_fail_nxt  = 4'hF;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_fail_nxt  = 4'h0;
            w_state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (w_hit == 1'b1) begin
          w_fail_nxt = r_fail;
        end else begin
          w_fail_nxt = r_fail | (4'b0001 << r_idx);
        end
        // Pass folds in the final vector's result on the same edge.
        if (r_idx == 2'd3) begin
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
          w_pass_nxt  = (w_fail_nxt == 4'h0);
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt            = r_idx + 2'd1;
          {w_a_nxt, w_b_nxt}   = r_idx + 2'd1;
          w_cnt_nxt            = 4'd0;
          w_state_nxt          = S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail_mask = r_fail;
  assign err_sel   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
// ============================================================================
// Module   : tb_gate_tt_checker
// Purpose  : Scoreboard bench driving two checkers (SETTLE_CYCLES 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  int         model_fn;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       dy2, a2, b2, busy2, done2, pass2, err2;
  logic [3:0] fm2;
  logic       dy1, a1, b1, busy1, done1, pass1, err1;
  logic [3:0] fm1;

  typedef struct {
    logic [3:0] fm;
    logic       p;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  gate_tt_checker #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .dut_y(dy2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fm2), .err_sel(err2)
  );

  gate_tt_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .dut_y(dy1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .err_sel(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: 0..6 real gates, 8 stuck-at-0, 9 stuck-at-1.
  function automatic logic model_out(input int m, input logic x, input logic y);
    case (m)
      0: return x & y;
      1: return x | y;
      2: return ~(x & y);
      3: return ~(x | y);
      4: return x ^ y;
      5: return ~(x ^ y);
      6: return ~x;
      9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb dy2 = model_out(model_fn, a2, b2);
  always_comb dy1 = model_out(model_fn, a1, b1);

  // Reference truth tables, bit i = expected output for {a,b} = i.
  function automatic logic [3:0] ref_tt(input int g);
    case (g)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      3: return 4'b0001;
      4: return 4'b0110;
      5: return 4'b1001;
      6: return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] model_tt(input int m);
    logic [3:0] t;
    logic [1:0] v;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      t[i] = model_out(m, v[1], v[0]);
    end
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_S2: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = q2.pop_front();
        chk("S2_fail_mask", int'(fm2), int'(e.fm));
        chk("S2_pass", int'(pass2), int'(e.p));
        chk("S2_err_sel", int'(err2), int'(e.e));
        chk("S2_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_S1: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        chk("S1_fail_mask", int'(fm1), int'(e.fm));
        chk("S1_pass", int'(pass1), int'(e.p));
        chk("S1_err_sel", int'(err1), int'(e.e));
        chk("S1_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_S2_ab"}, int'({a2, b2}), 0);
    chk({tag, "_S2_busy"}, int'(busy2), 0);
    chk({tag, "_S2_done"}, int'(done2), 0);
    chk({tag, "_S2_pass"}, int'(pass2), 0);
    chk({tag, "_S2_fm"}, int'(fm2), 0);
    chk({tag, "_S2_err"}, int'(err2), 0);
    chk({tag, "_S1_ab"}, int'({a1, b1}), 0);
    chk({tag, "_S1_busy"}, int'(busy1), 0);
    chk({tag, "_S1_pass"}, int'(pass1), 0);
    chk({tag, "_S1_fm"}, int'(fm1), 0);
    chk({tag, "_S1_err"}, int'(err1), 0);
  endtask

  // One complete run; repulse re-asserts start while vector 1 is applied.
  task automatic run(input int g, input int m, input bit repulse);
    exp_t e;
    int   c0;
    int   ev;
    int   eb;
    logic [3:0] efm;
    @(negedge clk);
    gate_sel = 3'(g);
    model_fn = m;
    start    = 1'b1;
    c0       = cyc;
    efm      = (g == 7) ? 4'hF : (ref_tt(g) ^ model_tt(m));
    e.fm  = efm;
    e.p   = (g != 7) && (efm == 4'h0);
    e.e   = (g == 7);
    e.cyc = c0 + 1 + ((g == 7) ? 0 : 12);
    q2.push_back(e);
    e.cyc = c0 + 1 + ((g == 7) ? 0 : 8);
    q1.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 3'($urandom_range(0, 7));
    for (int k = 0; k < 14; k++) begin
      ev = (g != 7 && k < 12) ? k / 3 : 0;
      eb = (g == 7) ? int'(k == 0) : int'(k <= 12);
      chk("S2_vector", int'({a2, b2}), ev);
      chk("S2_busy", int'(busy2), eb);
      ev = (g != 7 && k < 8) ? k / 2 : 0;
      eb = (g == 7) ? int'(k == 0) : int'(k <= 8);
      chk("S1_vector", int'({a1, b1}), ev);
      chk("S1_busy", int'(busy1), eb);
      start = (repulse && k == 4) ? 1'b1 : 1'b0;
      if (k == 4) gate_sel = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    start = 1'b0;
    chk("S2_held_fm", int'(fm2), int'(efm));
    chk("S2_held_pass", int'(pass2), int'((g != 7) && (efm == 4'h0)));
    chk("S1_held_fm", int'(fm1), int'(efm));
    chk("S1_held_err", int'(err1), int'(g == 7));
  endtask

  // Starts a run, then resets it while the S=2 checker is on vector 2.
  task automatic abort_run();
    @(negedge clk);
    gate_sel = 3'd0;
    model_fn = 0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_pre_vector", int'({a2, b2}), 2);
    rst = 1'b1;
    #1;
    chk_reset_vals("abort_now");
    repeat (2) @(negedge clk);
    chk_reset_vals("abort_hold");
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int m;
    int t;
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    model_fn = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    run(0, 0, 1'b0);
    run(4, 5, 1'b0);
    run(1, 8, 1'b0);
    run(7, 0, 1'b0);
    run(2, 2, 1'b1);
    abort_run();
    run(6, 6, 1'b0);
    run(3, 3, 1'b0);

    for (int r = 0; r < 12; r++) begin
      g = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && g < 7) begin
        m = g;
      end else begin
        t = $urandom_range(0, 8);
        m = (t < 7) ? t : t + 1;
      end
      run(g, m, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("S2_queue_drained", q2.size(), 0);
    chk("S1_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles the stimulus is held before the DUT output is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a truth-table run; sampled only in IDLE.
REQ-005 SHALL have port gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (of a), 7 reserved.
REQ-006 SHALL have port dut_y  input  1  observed output of the gate under test.
REQ-007 SHALL have port a  output  1  stimulus operand a, registered.
REQ-008 SHALL have port b  output  1  stimulus operand b, registered.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking run completion.
REQ-011 SHALL have port pass  output  1  1 when the last run had no mismatch; held until the next accepted start.
REQ-012 SHALL have port fail_mask  output  4  bit i set when vector i ({a,b}=i) mismatched; held until the next accepted start.
REQ-013 SHALL have port err_sel  output  1  last start carried gate_sel=7; held until the next accepted start.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL, at edge 0 (IDLE and start=1), latch gate_sel, clear fail_mask/pass/err_sel, set vector index idx=0, drive {a,b}=00, and enter SETTLE with the settle counter at 0.
REQ-016 SHALL stay in SETTLE while incrementing the counter, and move to SAMPLE at the edge where the counter reaches SETTLE_CYCLES-1, so that {a,b} is held SETTLE_CYCLES full cycles before sampling.
REQ-017 SHALL, at the SAMPLE edge, compare dut_y with the expected value for the latched gate_sel and {a,b}, and set fail_mask[idx] on mismatch.
REQ-018 SHALL, at the same SAMPLE edge, if idx<3, increment idx, drive {a,b}=idx+1 and return to SETTLE with the counter cleared; if idx=3, enter DONE.
REQ-019 SHALL apply the vector order 00, 01, 10, 11 (a=idx[1], b=idx[0]); each vector occupies SETTLE_CYCLES+1 cycles.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE, which starts at edge 4*(SETTLE_CYCLES+1); at that edge pass SHALL be set to (fail_mask==0), including the final sample, and {a,b} SHALL return to 00.
REQ-021 SHALL return from DONE to IDLE on the next edge unconditionally; start during DONE is ignored.
REQ-022 SHALL ignore start while busy=1; gate_sel changes during a run SHALL have no effect.
REQ-023 SHALL, for gate_sel=6, use expected value ~a and ignore b; b is still sequenced.
REQ-024 SHALL, on start with gate_sel=7, enter DONE directly at edge 0 with err_sel=1, pass=0, fail_mask=4'hF, and {a,b}=00.
REQ-025 SHALL treat a non-0/1 dut_y (X/Z in simulation) as a mismatch.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, idx=0, counter=0, a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, err_sel=0, and latched gate_sel=0.
REQ-027 SHALL abort any in-progress run immediately on rst, with no done pulse; the first start after rst falls SHALL begin a fresh run.

Verification
REQ-028 SHALL cover: correct AND model, gate_sel=0, SETTLE_CYCLES=2, start pulse -> {a,b} 00/01/10/11 each held 3 cycles; done pulses 12 cycles after start; pass=1; fail_mask=0000.
REQ-029 SHALL cover: XNOR model with gate_sel=4 -> fail_mask=1111, pass=0, done still pulses at cycle 12.
REQ-030 SHALL cover: dut_y stuck at 0 with gate_sel=1 -> fail_mask=1110, pass=0.
REQ-031 SHALL cover: gate_sel=7 start -> done in the next cycle, err_sel=1, pass=0, fail_mask=1111, busy high for 1 cycle.
REQ-032 SHALL cover: start re-pulsed during vector 1 -> ignored, with the run unchanged; rst asserted during vector 2 -> all outputs go to reset values at once with no done; a following start with a NOT model and gate_sel=6 -> pass=1.
REQ-033 SHALL cover: SETTLE_CYCLES=1 with a correct NOR model -> each vector held 2 cycles, done at cycle 8, pass=1.
